proc_multicycle: RTL and testbench

Parametrised multicycle datapath processor: a register file of `NREGS` × `DATA_W` registers, an accumulator `A`, an ALU result register `G` with zero flag, and a single shared bus, all sequenced by a fetch/execute FSM. It is the next generation of the board-level teaching processor. It adds:
- configurable width and register count;
- a valid/ready instruction-fetch handshake that replaces the free-running `Run` step counter;
- a two-word `mvi` instruction;
- `or`, `xor` and conditional `mvnz` instructions;
- a fully defined bus, with no latched mux.

It sits between the instruction memory/counter and the 7-segment/LED debug outputs in the top level.

---
 rtl/proc_pkg.sv | 28 ++
 rtl/proc_multicycle_if.sv | 23 ++
 rtl/proc_alu.sv | 33 +++
 rtl/proc_multicycle.sv | 150 +++++++++++++++
 tb/tb_proc_multicycle.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM states and
// instruction-width helpers.
package proc_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_MVNZ = 4'd10;

    typedef enum logic [2:0] {T0, T1, IMM, T2, T3} state_t;

    function automatic int ir_width(input int nregs);
        return 4 + 2 * $clog2(nregs);
    endfunction

    // Opcodes 2..9 all go through the A/G three-cycle ALU path
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/proc_multicycle_if.sv
// Fetch handshake and debug outputs of the multicycle processor; the
// processor uses the slave modport, the instruction memory side the master.
interface proc_multicycle_if #(parameter int DATA_W = 16);

    logic [DATA_W-1:0] DIN;
    logic              din_valid;
    logic              din_ready;
    logic              Done;
    logic              imediato;
    logic [DATA_W-1:0] BusWires;
    logic              Z;

    modport master (
        output DIN, din_valid,
        input  din_ready, Done, imediato, BusWires, Z
    );

    modport slave (
        input  DIN, din_valid,
        output din_ready, Done, imediato, BusWires, Z
    );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU; shifts use only the low $clog2(DATA_W) bits of b.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int SW = $clog2(DATA_W);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:  result = a << b[SW-1:0];
            OP_SRL:  result = a >> b[SW-1:0];
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/proc_multicycle.sv
// Multicycle processor: register file, A/G registers and one shared bus,
// sequenced by a fetch/execute FSM with a valid/ready instruction fetch.
module proc_multicycle
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clock,
    input  logic              Resetn,
    proc_multicycle_if.slave  cpu
);

    localparam int RW = $clog2(NREGS);
    localparam int IW = ir_width(NREGS);

    state_t            state;
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] g_reg;
    logic              z_reg;

    logic [3:0]        opcode;
    logic [RW-1:0]     rx;
    logic [RW-1:0]     ry;

    logic              reg_sel;
    logic [RW-1:0]     reg_idx;
    logic              din_sel;
    logic              g_sel;
    logic              write_en;
    logic              done;
    logic              ready;
    logic [DATA_W-1:0] bus;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    assign opcode = ir[IW-1:IW-4];
    assign rx     = ir[2*RW-1:RW];
    assign ry     = ir[RW-1:0];

    always_comb begin
        reg_sel  = 1'b0;
        reg_idx  = ry;
        din_sel  = 1'b0;
        g_sel    = 1'b0;
        write_en = 1'b0;
        done     = 1'b0;
        ready    = 1'b0;
        case (state)
            T0: ready = 1'b1;
            T1: begin
                if (opcode == OP_MV || opcode == OP_MVNZ) begin
                    reg_sel  = 1'b1;
                    write_en = (opcode == OP_MV) || !z_reg;
                    done     = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    reg_sel = 1'b1;
                    reg_idx = rx;
                end else if (opcode != OP_MVI) begin
                    done = 1'b1;
                end
            end
            IMM: begin
                ready = 1'b1;
                if (cpu.din_valid) begin
                    din_sel  = 1'b1;
                    write_en = 1'b1;
                    done     = 1'b1;
                end
            end
            T2: reg_sel = 1'b1;
            T3: begin
                g_sel    = 1'b1;
                write_en = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // Every register write takes its data from the bus, so one mux serves all
    always_comb begin
        if (reg_sel)
            bus = regs[reg_idx];
        else if (din_sel)
            bus = cpu.DIN;
        else if (g_sel)
            bus = g_reg;
        else
            bus = '0;
    end

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (bus),
        .opcode (opcode),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clock) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            z_reg <= 1'b1;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (write_en)
                regs[rx] <= bus;
            case (state)
                T0: if (cpu.din_valid) begin
                    ir    <= cpu.DIN[IW-1:0];
                    state <= T1;
                end
                T1: begin
                    if (opcode == OP_MVI) begin
                        state <= IMM;
                    end else if (is_alu_op(opcode)) begin
                        a_reg <= bus;
                        state <= T2;
                    end else begin
                        state <= T0;
                    end
                end
                IMM: if (cpu.din_valid) state <= T0;
                T2: begin
                    g_reg <= alu_result;
                    z_reg <= alu_zero;
                    state <= T3;
                end
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Reset forces the debug outputs quiet even while state is mid-instruction
    assign cpu.din_ready = ready;
    assign cpu.Done      = done & Resetn;
    assign cpu.imediato  = Resetn && (state == IMM) && cpu.din_valid;
    assign cpu.BusWires  = Resetn ? bus : '0;
    assign cpu.Z         = z_reg;

endmodule

// File: tb/tb_proc_multicycle.sv
// Scoreboard bench for proc_multicycle: a small reference model predicts each
// instruction's Done latency, bus value, imediato and Z.
module tb_proc_multicycle;
    import proc_pkg::*;

    typedef struct {
        logic [15:0] bus;
        int          lat;
        logic        imm;
        logic        z;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] imm;
        int          delay;
    } instr_t;

    logic clock = 1'b0;
    logic Resetn;

    proc_multicycle_if #(.DATA_W(16)) cpu ();

    proc_multicycle #(.DATA_W(16), .NREGS(8)) dut (
        .clock  (clock),
        .Resetn (Resetn),
        .cpu    (cpu)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [15:0] mregs [8];
    logic        mz;

    int          act_lat;
    logic [15:0] act_bus;
    logic        act_imm;
    logic        act_z;
    logic        act_wait_ok;

    function automatic instr_t mk(input logic [3:0] op, input logic [2:0] rx,
                                  input logic [2:0] ry, input logic [15:0] imm,
                                  input int delay);
        instr_t t;
        t.op = op; t.rx = rx; t.ry = ry; t.imm = imm; t.delay = delay;
        return t;
    endfunction

    function automatic logic [15:0] alu_model(input logic [3:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_SLT:  return (a < b) ? 16'd1 : 16'd0;
            OP_SLL:  return a << b[3:0];
            OP_SRL:  return a >> b[3:0];
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        mz = 1'b1;
    endtask

    // Predicts one instruction into the scoreboard, then drives it and
    // captures what the DUT shows in its Done cycle (lat = -1 on timeout).
    task automatic apply_stimulus(input instr_t t);
        exp_t        e;
        logic [15:0] res;
        logic [15:0] word;
        e.bus = 16'd0; e.lat = 1; e.imm = 1'b0;
        case (t.op)
            OP_MV: begin
                e.bus = mregs[t.ry];
                mregs[t.rx] = mregs[t.ry];
            end
            OP_MVNZ: begin
                e.bus = mregs[t.ry];
                if (!mz) mregs[t.rx] = mregs[t.ry];
            end
            OP_MVI: begin
                e.bus = t.imm; e.lat = 2 + t.delay; e.imm = 1'b1;
                mregs[t.rx] = t.imm;
            end
            OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL, OP_OR, OP_XOR: begin
                res = alu_model(t.op, mregs[t.rx], mregs[t.ry]);
                e.bus = res; e.lat = 3;
                mregs[t.rx] = res;
                mz = (res == 16'd0);
            end
            default: ;
        endcase
        e.z = mz;
        sb_q.push_back(e);

        word = 16'($urandom);
        word[9:0] = {t.op, t.rx, t.ry};
        @(negedge clock);
        cpu.DIN = word;
        cpu.din_valid = 1'b1;
        act_lat = -1; act_bus = 16'hxxxx; act_imm = 1'bx; act_z = 1'bx; act_wait_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            cpu.din_valid = 1'b0;
            cpu.DIN = 16'($urandom);
            if (t.op == OP_MVI && c >= 2 + t.delay) begin
                cpu.din_valid = 1'b1;
                cpu.DIN = t.imm;
            end
            #1;
            if (t.op == OP_MVI && c >= 2 && c < 2 + t.delay &&
                (cpu.din_ready !== 1'b1 || cpu.BusWires !== 16'd0 || cpu.Done !== 1'b0))
                act_wait_ok = 1'b0;
            if (cpu.Done === 1'b1) begin
                act_lat = c; act_bus = cpu.BusWires; act_imm = cpu.imediato; act_z = cpu.Z;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cpu.din_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        cpu.din_valid = 1'b0;
        cpu.DIN = 16'h0000;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (cpu.Done !== 1'b0 || cpu.imediato !== 1'b0 || cpu.BusWires !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: Done=%b imediato=%b bus=%h, required 0 0 0000",
                     cpu.Done, cpu.imediato, cpu.BusWires);
        end
        @(negedge clock);
        Resetn = 1'b1;
        #1;
        checks++;
        if (cpu.din_ready !== 1'b1 || cpu.Done !== 1'b0 || cpu.BusWires !== 16'd0) begin
            failures++;
            $display("[TB] FAIL first_t0: din_ready=%b Done=%b bus=%h, required 1 0 0000",
                     cpu.din_ready, cpu.Done, cpu.BusWires);
        end
        checks++;
        if (cpu.Z !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_z: Z=%b, required 1", cpu.Z);
        end
    endtask

    task automatic test_mvi();
        instr_t prog[$];
        exp_t   e;
        prog.push_back(mk(OP_MVI, 3'd0, 3'd0, 16'h00A5, 0));
        prog.push_back(mk(OP_MV,  3'd0, 3'd0, 16'h0000, 0));
        foreach (prog[i]) begin
            apply_stimulus(prog[i]);
            e = sb_q.pop_front();
            checks++;
            if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm || act_z !== e.z) begin
                failures++;
                $display("[TB] FAIL mvi[%0d]: lat=%0d bus=%h imediato=%b Z=%b, required lat=%0d bus=%h imediato=%b Z=%b",
                         i, act_lat, act_bus, act_imm, act_z, e.lat, e.bus, e.imm, e.z);
            end
        end
    endtask

    task automatic test_mvi_wait();
        exp_t e;
        apply_stimulus(mk(OP_MVI, 3'd1, 3'd0, 16'h0007, 3));
        e = sb_q.pop_front();
        checks++;
        if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm) begin
            failures++;
            $display("[TB] FAIL mvi_wait: lat=%0d bus=%h imediato=%b, required lat=%0d bus=%h imediato=%b",
                     act_lat, act_bus, act_imm, e.lat, e.bus, e.imm);
        end
        checks++;
        if (act_wait_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mvi_wait_idle: wait cycles ok=%b, required din_ready=1 bus=0 Done=0", act_wait_ok);
        end
    endtask

    task automatic test_add();
        instr_t prog[$];
        exp_t   e;
        prog.push_back(mk(OP_MVI, 3'd2, 3'd0, 16'hFFFB, 0));
        prog.push_back(mk(OP_ADD, 3'd1, 3'd2, 16'h0000, 0));
        prog.push_back(mk(OP_MV,  3'd1, 3'd1, 16'h0000, 0));
        foreach (prog[i]) begin
            apply_stimulus(prog[i]);
            e = sb_q.pop_front();
            checks++;
            if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm || act_z !== e.z) begin
                failures++;
                $display("[TB] FAIL add[%0d]: lat=%0d bus=%h imediato=%b Z=%b, required lat=%0d bus=%h imediato=%b Z=%b",
                         i, act_lat, act_bus, act_imm, act_z, e.lat, e.bus, e.imm, e.z);
            end
        end
        checks++;
        if (act_bus !== 16'h0002) begin
            failures++;
            $display("[TB] FAIL add_r1: r1=%h, required 0002", act_bus);
        end
    endtask

    task automatic test_sub_mvnz();
        instr_t prog[$];
        exp_t   e;
        prog.push_back(mk(OP_MVI,  3'd4, 3'd0, 16'h1234, 1));
        prog.push_back(mk(OP_MVI,  3'd3, 3'd0, 16'h0009, 0));
        prog.push_back(mk(OP_SUB,  3'd3, 3'd3, 16'h0000, 0));
        prog.push_back(mk(OP_MVNZ, 3'd4, 3'd1, 16'h0000, 0));
        prog.push_back(mk(OP_MV,   3'd4, 3'd4, 16'h0000, 0));
        prog.push_back(mk(OP_ADD,  3'd3, 3'd1, 16'h0000, 0));
        prog.push_back(mk(OP_MVNZ, 3'd4, 3'd1, 16'h0000, 0));
        prog.push_back(mk(OP_MV,   3'd4, 3'd4, 16'h0000, 0));
        foreach (prog[i]) begin
            apply_stimulus(prog[i]);
            e = sb_q.pop_front();
            checks++;
            if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm || act_z !== e.z) begin
                failures++;
                $display("[TB] FAIL sub_mvnz[%0d]: lat=%0d bus=%h imediato=%b Z=%b, required lat=%0d bus=%h imediato=%b Z=%b",
                         i, act_lat, act_bus, act_imm, act_z, e.lat, e.bus, e.imm, e.z);
            end
        end
    endtask

    task automatic test_slt_shift_logic();
        instr_t prog[$];
        exp_t   e;
        prog.push_back(mk(OP_MVI,  3'd5, 3'd0, 16'h0003, 0));
        prog.push_back(mk(OP_MVI,  3'd6, 3'd0, 16'h0005, 0));
        prog.push_back(mk(OP_SLT,  3'd5, 3'd6, 16'h0000, 0));
        prog.push_back(mk(OP_MVI,  3'd5, 3'd0, 16'h0003, 0));
        prog.push_back(mk(OP_SLT,  3'd6, 3'd5, 16'h0000, 0));
        prog.push_back(mk(OP_MVI,  3'd0, 3'd0, 16'h0001, 0));
        prog.push_back(mk(OP_MVI,  3'd7, 3'd0, 16'h000F, 0));
        prog.push_back(mk(OP_SLL,  3'd0, 3'd7, 16'h0000, 0));
        prog.push_back(mk(OP_MVI,  3'd7, 3'd0, 16'h0013, 0));
        prog.push_back(mk(OP_SRL,  3'd0, 3'd7, 16'h0000, 0));
        prog.push_back(mk(OP_MVI,  3'd1, 3'd0, 16'h00F0, 0));
        prog.push_back(mk(OP_MVI,  3'd2, 3'd0, 16'h0F0F, 0));
        prog.push_back(mk(OP_OR,   3'd1, 3'd2, 16'h0000, 0));
        prog.push_back(mk(OP_XOR,  3'd1, 3'd2, 16'h0000, 0));
        prog.push_back(mk(OP_AND,  3'd1, 3'd2, 16'h0000, 0));
        prog.push_back(mk(OP_MVNZ, 3'd5, 3'd0, 16'h0000, 0));
        prog.push_back(mk(OP_MV,   3'd5, 3'd5, 16'h0000, 0));
        prog.push_back(mk(4'd12,   3'd5, 3'd0, 16'h0000, 0));
        foreach (prog[i]) begin
            apply_stimulus(prog[i]);
            e = sb_q.pop_front();
            checks++;
            if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm || act_z !== e.z) begin
                failures++;
                $display("[TB] FAIL alu_ops[%0d]: lat=%0d bus=%h imediato=%b Z=%b, required lat=%0d bus=%h imediato=%b Z=%b",
                         i, act_lat, act_bus, act_imm, act_z, e.lat, e.bus, e.imm, e.z);
            end
        end
    endtask

    task automatic test_back_to_back();
        instr_t prog[$];
        exp_t   e;
        prog.push_back(mk(OP_MV,  3'd3, 3'd0, 16'h0000, 0));
        prog.push_back(mk(OP_ADD, 3'd3, 3'd3, 16'h0000, 0));
        prog.push_back(mk(OP_MV,  3'd2, 3'd3, 16'h0000, 0));
        prog.push_back(mk(OP_MV,  3'd2, 3'd2, 16'h0000, 0));
        foreach (prog[i]) begin
            apply_stimulus(prog[i]);
            e = sb_q.pop_front();
            checks++;
            if (act_lat !== e.lat || act_bus !== e.bus || act_imm !== e.imm || act_z !== e.z) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d]: lat=%0d bus=%h imediato=%b Z=%b, required lat=%0d bus=%h imediato=%b Z=%b",
                         i, act_lat, act_bus, act_imm, act_z, e.lat, e.bus, e.imm, e.z);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [15:0] word;
        apply_stimulus(mk(OP_MVI, 3'd1, 3'd0, 16'h0007, 0));
        e = sb_q.pop_front();
        checks++;
        if (act_lat !== e.lat || act_bus !== e.bus) begin
            failures++;
            $display("[TB] FAIL reset_mid_setup: lat=%0d bus=%h, required lat=%0d bus=%h",
                     act_lat, act_bus, e.lat, e.bus);
        end
        word = 16'h0000;
        word[9:0] = {OP_ADD, 3'd1, 3'd1};
        @(negedge clock);
        cpu.DIN = word;
        cpu.din_valid = 1'b1;
        idle(2);
        Resetn = 1'b0;
        #1;
        checks++;
        if (cpu.Done !== 1'b0 || cpu.BusWires !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs: Done=%b bus=%h, required 0 0000", cpu.Done, cpu.BusWires);
        end
        @(negedge clock);
        Resetn = 1'b1;
        model_reset();
        #1;
        checks++;
        if (cpu.din_ready !== 1'b1 || cpu.Z !== 1'b1 || cpu.Done !== 1'b0 || cpu.BusWires !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_state: din_ready=%b Z=%b Done=%b bus=%h, required 1 1 0 0000",
                     cpu.din_ready, cpu.Z, cpu.Done, cpu.BusWires);
        end
        apply_stimulus(mk(OP_MV, 3'd1, 3'd1, 16'h0000, 0));
        e = sb_q.pop_front();
        checks++;
        if (act_lat !== e.lat || act_bus !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_mid_r1: lat=%0d r1=%h, required lat=%0d r1=0000", act_lat, act_bus, e.lat);
        end
        apply_stimulus(mk(OP_MV, 3'd4, 3'd4, 16'h0000, 0));
        e = sb_q.pop_front();
        checks++;
        if (act_bus !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_mid_r4: r4=%h, required 0000", act_bus);
        end
    endtask

    initial begin
        cpu.DIN = 16'h0000;
        cpu.din_valid = 1'b0;
        Resetn = 1'b0;
        test_reset();
        test_mvi();
        test_mvi_wait();
        test_add();
        test_sub_mvnz();
        test_slt_shift_logic();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
